fft_sample_bank: RTL and testbench

FFT_SAMPLE_BANK -- requirements
Module: fft_sample_bank

---
 rtl/fft_sample_bank.sv | 172 +++++++++++++++++
 tb/tb_fft_sample_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_bank.sv
// Dual-ported sample bank that the IO side and the FFT engine take turns owning: LOAD, then COMPUTE, then UNLOAD.
// Defining FFT_BANK_BITREV_EN bit-reverses the IO-side write addresses before they reach memory.
module fft_sample_bank #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_wr_en,
  input  logic [address_width-1:0]   io_wr_addr1,
  input  logic [address_width-1:0]   io_wr_addr2,
  input  logic [2*word_size-1:0]     io_wr_data1,
  input  logic [2*word_size-1:0]     io_wr_data2,
  input  logic                       io_rd_en,
  input  logic [address_width-1:0]   io_rd_addr1,
  input  logic [address_width-1:0]   io_rd_addr2,
  output logic [2*word_size-1:0]     io_rd_data1,
  output logic [2*word_size-1:0]     io_rd_data2,
  output logic                       io_rd_valid,
  input  logic                       fft_wr_en,
  input  logic [address_width-1:0]   fft_wr_addr1,
  input  logic [address_width-1:0]   fft_wr_addr2,
  input  logic [address_width-1:0]   fft_rd_addr1,
  input  logic [address_width-1:0]   fft_rd_addr2,
  input  logic [2*word_size-1:0]     fft_wr_data1,
  input  logic [2*word_size-1:0]     fft_wr_data2,
  output logic [2*word_size-1:0]     fft_rd_data1,
  output logic [2*word_size-1:0]     fft_rd_data2,
  output logic                       fft_start,
  input  logic                       fft_done,
  output logic                       fft_busy,
  output logic [1:0]                 bank_state,
  output logic                       protocol_err
);

  localparam int SW = 2 * word_size;
  // Each strobe moves two samples, so a frame is N/2 strobes.
  localparam logic [address_width-1:0] LAST = address_width'(N / 2 - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    COMPUTE = 2'b01,
    UNLOAD  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [address_width-1:0] wr_cnt, rd_cnt;
  logic [SW-1:0]            mem [N];

  logic                     io_wr_ok, io_rd_ok, fft_wr_ok, fft_done_ok;
  logic                     bad_access;
  logic [address_width-1:0] io_wa1, io_wa2;
  logic                     mem_we;
  logic [address_width-1:0] wa1, wa2;
  logic [SW-1:0]            wd1, wd2;

  logic                     start_p1;
  logic                     vld_p1;
  logic [SW-1:0]            io_rd1_p1, io_rd2_p1;
  logic [SW-1:0]            fft_rd1_p1, fft_rd2_p1;

`ifdef FFT_BANK_BITREV_EN
  function automatic logic [address_width-1:0] bit_rev(input logic [address_width-1:0] a);
    logic [address_width-1:0] r;
    for (int i = 0; i < address_width; i++) r[i] = a[address_width-1-i];
    return r;
  endfunction

  assign io_wa1 = bit_rev(io_wr_addr1);
  assign io_wa2 = bit_rev(io_wr_addr2);
`else
  assign io_wa1 = io_wr_addr1;
  assign io_wa2 = io_wr_addr2;
`endif

  // Strobes only count when their owner holds the bank; anything else is a protocol error.
  assign io_wr_ok    = io_wr_en  && (state == LOAD);
  assign io_rd_ok    = io_rd_en  && (state == UNLOAD);
  assign fft_wr_ok   = fft_wr_en && (state == COMPUTE);
  assign fft_done_ok = fft_done  && (state == COMPUTE);
  assign bad_access  = (io_wr_en && !io_wr_ok) || (io_rd_en && !io_rd_ok) ||
                       (fft_wr_en && !fft_wr_ok) || (fft_done && !fft_done_ok);

  always_comb begin
    mem_we = io_wr_ok || fft_wr_ok;
    wa1    = fft_wr_addr1;
    wa2    = fft_wr_addr2;
    wd1    = fft_wr_data1;
    wd2    = fft_wr_data2;
    if (state == LOAD) begin
      wa1 = io_wa1;
      wa2 = io_wa2;
      wd1 = io_wr_data1;
      wd2 = io_wr_data2;
    end
  end

  // Port 2 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wa1] <= wd1;
      mem[wa2] <= wd2;
    end
  end

  // Stage p1: registered reads; same-edge writes are not yet visible, so old data is returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      io_rd1_p1  <= '0;
      io_rd2_p1  <= '0;
      fft_rd1_p1 <= '0;
      fft_rd2_p1 <= '0;
    end else begin
      vld_p1     <= io_rd_ok;
      fft_rd1_p1 <= mem[fft_rd_addr1];
      fft_rd2_p1 <= mem[fft_rd_addr2];
      if (io_rd_ok) begin
        io_rd1_p1 <= mem[io_rd_addr1];
        io_rd2_p1 <= mem[io_rd_addr2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      start_p1     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_p1 <= io_wr_ok && (wr_cnt == LAST);
      if (bad_access) protocol_err <= 1'b1;
      if (io_wr_ok) wr_cnt <= wr_cnt + 1'b1;
      if (io_rd_ok) begin
        if (rd_cnt == LAST) begin
          rd_cnt <= '0;
          wr_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (io_wr_ok && (wr_cnt == LAST)) state_nxt = COMPUTE;
      COMPUTE: if (fft_done_ok) state_nxt = UNLOAD;
      UNLOAD:  if (io_rd_ok && (rd_cnt == LAST)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    fft_busy   = (state == COMPUTE);
    bank_state = state;
  end

  assign fft_start    = start_p1;
  assign io_rd_valid  = vld_p1;
  assign io_rd_data1  = io_rd1_p1;
  assign io_rd_data2  = io_rd2_p1;
  assign fft_rd_data1 = fft_rd1_p1;
  assign fft_rd_data2 = fft_rd2_p1;

endmodule

// File: tb/tb_fft_sample_bank.sv
// Directed bench for fft_sample_bank: load/compute/unload handshake, port rules, protocol errors and reset recovery.
// Build with FFT_BANK_BITREV_EN to exercise the bit-reversed IO write path.
module tb_fft_sample_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_wr_en, io_rd_en, fft_wr_en, fft_done;
  logic [4:0]  io_wr_addr1, io_wr_addr2, io_rd_addr1, io_rd_addr2;
  logic [4:0]  fft_wr_addr1, fft_wr_addr2, fft_rd_addr1, fft_rd_addr2;
  logic [31:0] io_wr_data1, io_wr_data2, fft_wr_data1, fft_wr_data2;
  logic [31:0] io_rd_data1, io_rd_data2, fft_rd_data1, fft_rd_data2;
  logic        io_rd_valid, fft_start, fft_busy, protocol_err;
  logic [1:0]  bank_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_mem [32];

  fft_sample_bank #(.N(32), .word_size(16), .address_width(5)) dut (
    .clk(clk), .reset(reset),
    .io_wr_en(io_wr_en), .io_wr_addr1(io_wr_addr1), .io_wr_addr2(io_wr_addr2),
    .io_wr_data1(io_wr_data1), .io_wr_data2(io_wr_data2),
    .io_rd_en(io_rd_en), .io_rd_addr1(io_rd_addr1), .io_rd_addr2(io_rd_addr2),
    .io_rd_data1(io_rd_data1), .io_rd_data2(io_rd_data2), .io_rd_valid(io_rd_valid),
    .fft_wr_en(fft_wr_en), .fft_wr_addr1(fft_wr_addr1), .fft_wr_addr2(fft_wr_addr2),
    .fft_rd_addr1(fft_rd_addr1), .fft_rd_addr2(fft_rd_addr2),
    .fft_wr_data1(fft_wr_data1), .fft_wr_data2(fft_wr_data2),
    .fft_rd_data1(fft_rd_data1), .fft_rd_data2(fft_rd_data2),
    .fft_start(fft_start), .fft_done(fft_done), .fft_busy(fft_busy),
    .bank_state(bank_state), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [4:0] map_wr(input logic [4:0] a);
`ifdef FFT_BANK_BITREV_EN
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = a[4-i];
    return r;
`else
    return a;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    io_wr_en = 0; io_rd_en = 0; fft_wr_en = 0; fft_done = 0;
    io_wr_addr1 = 0; io_wr_addr2 = 0; io_rd_addr1 = 0; io_rd_addr2 = 0;
    fft_wr_addr1 = 0; fft_wr_addr2 = 0; fft_rd_addr1 = 0; fft_rd_addr2 = 0;
    io_wr_data1 = 0; io_wr_data2 = 0; fft_wr_data1 = 0; fft_wr_data2 = 0;
  endtask

  // One accepted IO write strobe; the expected memory image follows it.
  task automatic io_wr(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d1, input logic [31:0] d2);
    io_wr_en = 1; io_wr_addr1 = a1; io_wr_addr2 = a2; io_wr_data1 = d1; io_wr_data2 = d2;
    exp_mem[map_wr(a1)] = d1;
    exp_mem[map_wr(a2)] = d2;
    tick;
    io_wr_en = 0;
  endtask

  task automatic io_rd(input logic [4:0] a1, input logic [4:0] a2);
    io_rd_en = 1; io_rd_addr1 = a1; io_rd_addr2 = a2;
    tick;
    io_rd_en = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 0;
    #3;
    n_checks++; if (bank_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", bank_state); end
    n_checks++; if (fft_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", fft_busy); end
    n_checks++; if (fft_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", fft_start); end
    n_checks++; if (io_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", io_rd_valid); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", protocol_err); end
    n_checks++; if (io_rd_data1 !== 32'h0 || io_rd_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_io_rd: got %h/%h want 0/0", io_rd_data1, io_rd_data2); end
    n_checks++; if (fft_rd_data1 !== 32'h0 || fft_rd_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_fft_rd: got %h/%h want 0/0", fft_rd_data1, fft_rd_data2); end
    repeat (2) tick;
    reset = 1;
    tick;
  endtask

  task automatic test_load;
    for (int k = 0; k < 16; k++) begin
      io_wr(5'(2*k), 5'(2*k+1), 32'(2*k), 32'(2*k+1));
      n_checks++; if (fft_start !== (k == 15)) begin n_fail++; $display("FAIL load_start[%0d]: got %b want %b", k, fft_start, (k == 15)); end
      n_checks++; if (bank_state !== ((k == 15) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL load_state[%0d]: got %b", k, bank_state); end
    end
    n_checks++; if (fft_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", fft_busy); end
    tick;
    n_checks++; if (fft_start !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width: got %b want 0", fft_start); end
    n_checks++; if (bank_state !== 2'b01) begin n_fail++; $display("FAIL compute_hold: got %b want 01", bank_state); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL load_no_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_compute;
    logic [31:0] old5;
    fft_rd_addr1 = 5; fft_rd_addr2 = 6;
    tick;
    n_checks++; if (fft_rd_data1 !== exp_mem[5]) begin n_fail++; $display("FAIL fft_rd1: got %h want %h", fft_rd_data1, exp_mem[5]); end
    n_checks++; if (fft_rd_data2 !== exp_mem[6]) begin n_fail++; $display("FAIL fft_rd2: got %h want %h", fft_rd_data2, exp_mem[6]); end
    // Write and read address 5 in the same cycle: old value must come back.
    old5 = exp_mem[5];
    fft_wr_en = 1; fft_wr_addr1 = 5; fft_wr_data1 = 32'hABCD1234; fft_wr_addr2 = 9; fft_wr_data2 = 32'h99990009;
    tick;
    exp_mem[5] = 32'hABCD1234; exp_mem[9] = 32'h99990009;
    n_checks++; if (fft_rd_data1 !== old5) begin n_fail++; $display("FAIL rd_during_wr: got %h want %h", fft_rd_data1, old5); end
    fft_wr_addr1 = 7; fft_wr_data1 = 32'h11111111; fft_wr_addr2 = 7; fft_wr_data2 = 32'h22222222;
    tick;
    exp_mem[7] = 32'h22222222;
    n_checks++; if (fft_rd_data1 !== 32'hABCD1234) begin n_fail++; $display("FAIL fft_write: got %h want abcd1234", fft_rd_data1); end
    fft_wr_en = 0; fft_rd_addr1 = 7; fft_rd_addr2 = 9;
    tick;
    n_checks++; if (fft_rd_data1 !== 32'h22222222) begin n_fail++; $display("FAIL same_addr_port2: got %h want 22222222", fft_rd_data1); end
    n_checks++; if (fft_rd_data2 !== 32'h99990009) begin n_fail++; $display("FAIL fft_write2: got %h want 99990009", fft_rd_data2); end
  endtask

  task automatic test_protocol_err;
    io_wr_en = 1; io_wr_addr1 = 0; io_wr_addr2 = 1; io_wr_data1 = 32'hDEAD0000; io_wr_data2 = 32'hDEAD0001;
    tick;
    io_wr_en = 0;
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", protocol_err); end
    n_checks++; if (bank_state !== 2'b01) begin n_fail++; $display("FAIL err_state: got %b want 01", bank_state); end
    fft_rd_addr1 = map_wr(5'd0);
    tick;
    n_checks++; if (fft_rd_data1 !== exp_mem[map_wr(5'd0)]) begin n_fail++; $display("FAIL err_mem_kept: got %h want %h", fft_rd_data1, exp_mem[map_wr(5'd0)]); end
    fft_done = 1;
    tick;
    fft_done = 0;
    n_checks++; if (bank_state !== 2'b10) begin n_fail++; $display("FAIL done_to_unload: got %b want 10", bank_state); end
    n_checks++; if (fft_busy !== 1'b0) begin n_fail++; $display("FAIL unload_busy: got %b want 0", fft_busy); end
  endtask

  task automatic test_unload;
    io_rd(5, 6);
    n_checks++; if (io_rd_data1 !== exp_mem[5] || io_rd_data2 !== exp_mem[6]) begin n_fail++; $display("FAIL unload_first: got %h/%h want %h/%h", io_rd_data1, io_rd_data2, exp_mem[5], exp_mem[6]); end
    n_checks++; if (io_rd_valid !== 1'b1) begin n_fail++; $display("FAIL unload_valid: got %b want 1", io_rd_valid); end
    tick;
    n_checks++; if (io_rd_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %b want 0", io_rd_valid); end
    n_checks++; if (io_rd_data1 !== exp_mem[5]) begin n_fail++; $display("FAIL data_hold: got %h want %h", io_rd_data1, exp_mem[5]); end
    for (int k = 1; k < 16; k++) begin
      io_rd(5'(2*k), 5'(2*k+1));
      n_checks++; if (io_rd_data1 !== exp_mem[2*k] || io_rd_data2 !== exp_mem[2*k+1]) begin n_fail++; $display("FAIL unload_rd[%0d]: got %h/%h want %h/%h", k, io_rd_data1, io_rd_data2, exp_mem[2*k], exp_mem[2*k+1]); end
      n_checks++; if (bank_state !== ((k == 15) ? 2'b00 : 2'b10)) begin n_fail++; $display("FAIL unload_state[%0d]: got %b", k, bank_state); end
    end
    n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_mid_frame_reset;
    for (int k = 0; k < 7; k++) io_wr(5'(2*k), 5'(2*k+1), 32'h100 + 32'(2*k), 32'h100 + 32'(2*k+1));
    reset = 0;
    #2;
    n_checks++; if (protocol_err !== 1'b0 || bank_state !== 2'b00) begin n_fail++; $display("FAIL midreset: got err=%b state=%b want 0/00", protocol_err, bank_state); end
    tick;
    reset = 1;
    tick;
    for (int k = 0; k < 16; k++) begin
      io_wr(31, 31, 32'hB00 + 32'(k), 32'hC00 + 32'(k));
      n_checks++; if (fft_start !== (k == 15)) begin n_fail++; $display("FAIL reload_start[%0d]: got %b want %b", k, fft_start, (k == 15)); end
    end
    // fft_done in the start cycle: COMPUTE lasts a single cycle.
    fft_done = 1;
    tick;
    fft_done = 0;
    n_checks++; if (bank_state !== 2'b10) begin n_fail++; $display("FAIL start_with_done: got %b want 10", bank_state); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL done_honoured_err: got %b want 0", protocol_err); end
    for (int k = 0; k < 16; k++) begin
      io_rd(5'(k), 5'(31 - k));
      n_checks++; if (io_rd_data1 !== exp_mem[k] || io_rd_data2 !== exp_mem[31-k]) begin n_fail++; $display("FAIL frame2_rd[%0d]: got %h/%h want %h/%h", k, io_rd_data1, io_rd_data2, exp_mem[k], exp_mem[31-k]); end
    end
    n_checks++; if (bank_state !== 2'b00) begin n_fail++; $display("FAIL frame2_end: got %b want 00", bank_state); end
    n_checks++; if (exp_mem[31] !== 32'hC0F) begin n_fail++; $display("FAIL model_port2: got %h want c0f", exp_mem[31]); end
  endtask

`ifdef FFT_BANK_BITREV_EN
  task automatic test_bitrev;
    for (int k = 0; k < 16; k++) io_wr(5'(2*k), 5'(2*k+1), 32'(2*k), (k == 0) ? 32'h11 : 32'(2*k+1));
    fft_done = 1;
    tick;
    fft_done = 0;
    io_rd(16, 1);
    n_checks++; if (io_rd_data1 !== 32'h00000011) begin n_fail++; $display("FAIL bitrev_rd16: got %h want 00000011", io_rd_data1); end
    for (int k = 1; k < 16; k++) io_rd(5'(k), 5'(k));
    n_checks++; if (bank_state !== 2'b00) begin n_fail++; $display("FAIL bitrev_end: got %b want 00", bank_state); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_protocol_err();
    test_unload();
    test_mid_frame_reset();
`ifdef FFT_BANK_BITREV_EN
    test_bitrev();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
